// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with a 16-entry receive FIFO, status and debug counters.
// Build option: define UART_SIM_BAUD_EN to reset the bit period to 40 cycles for short simulations.
module uart_periph #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             RxD,
  output logic             TxD
);

`ifdef UART_SIM_BAUD_EN
  localparam logic [31:0] CPB_RST = 32'd40;
`else
  localparam logic [31:0] CPB_RST = 32'd217;
`endif

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Register file
  logic [1:0]  ctrl;
  logic [31:0] cpb;
  logic [31:0] scratch [4];
  logic [31:0] char_count, fifo_wr_count, fifo_full_count;
  logic        rx_en, tx_en;

  assign rx_en = ctrl[0];
  assign tx_en = ctrl[1];

  logic wr_acc, rd_strobe, rd_strobe_d;
  assign wr_acc    = cs & wen;
  assign rd_strobe = cs & ~wen & ((addr == 4'd0) || (addr == 4'd5));

  // Transmitter
  tx_state_t   tx_state, tx_state_nxt;
  logic [31:0] tx_cnt, tx_cpb;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_accept, tx_tick, tx_idle;

  assign tx_accept = wr_acc & (addr == 4'd0) & tx_en & (tx_state == TX_IDLE);
  assign tx_tick   = (tx_cnt == tx_cpb - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_nxt = TX_START;
      TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    TxD     = 1'b1;
    tx_idle = 1'b0;
    case (tx_state)
      TX_IDLE:  tx_idle = 1'b1;
      TX_START: TxD = 1'b0;
      TX_DATA:  TxD = tx_sh[0];
      default:  TxD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_cpb <= CPB_RST;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_accept) begin
      tx_cnt <= '0;
      tx_cpb <= cpb;
      tx_bit <= '0;
      tx_sh  <= din[7:0];
    end else if (tx_state != TX_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_state == TX_DATA) begin
          tx_sh  <= {1'b1, tx_sh[7:1]};
          tx_bit <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 32'd1;
      end
    end
  end

  // Receiver: two-flop synchronizer, falling-edge start detect, mid-bit sampling
  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_s1, rx_s2, rx_prev, rx_fall;
  logic [31:0] rx_cnt, rx_cpb, rx_lim;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_data;
  logic        rx_tick, rx_start, rx_sample, rx_stop_ok, rx_stop_brk;
  logic        rx_valid, brk;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_lim  = (rx_state == RX_START) ? {1'b0, rx_cpb[31:1]} : rx_cpb;
  assign rx_tick = (rx_cnt == rx_lim - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RxD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    if (!rx_en) begin
      rx_state_nxt = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
        RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
        default:  rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_start    = 1'b0;
    rx_sample   = 1'b0;
    rx_stop_ok  = 1'b0;
    rx_stop_brk = 1'b0;
    if (rx_en) begin
      case (rx_state)
        RX_IDLE: rx_start  = rx_fall;
        RX_DATA: rx_sample = rx_tick;
        RX_STOP: begin
          rx_stop_ok  = rx_tick & rx_s2;
          rx_stop_brk = rx_tick & ~rx_s2 & (rx_sh == 8'h00);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_cpb <= CPB_RST;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (rx_start) begin
      rx_cnt <= '0;
      rx_cpb <= cpb;
      rx_bit <= '0;
    end else if (rx_state != RX_IDLE) begin
      rx_cnt <= rx_tick ? 32'd0 : rx_cnt + 32'd1;
      if (rx_sample) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      brk      <= 1'b0;
    end else begin
      rx_valid <= rx_stop_ok;
      if (rx_stop_ok) begin
        rx_data <= rx_sh;
        brk     <= 1'b0;
      end else if (rx_stop_brk) begin
        brk <= 1'b1;
      end
    end
  end

  // Receive FIFO; a separate occupancy count distinguishes full from empty
  logic [7:0] mem [16];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] fifo_cnt;
  logic [7:0] head, rx_buf;
  logic       full, empty, pop, push, drop;

  assign full  = (fifo_cnt == 5'd16);
  assign empty = (fifo_cnt == 5'd0);
  assign head  = mem[rd_ptr];
  assign pop   = rd_strobe & ~rd_strobe_d & ~empty;
  assign push  = rx_valid & (~full | pop);
  assign drop  = rx_valid & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      rx_buf      <= '0;
      rd_strobe_d <= 1'b0;
    end else begin
      rd_strobe_d <= rd_strobe;
      if (!rd_strobe) rx_buf <= head;
      if (push) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + 4'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 4'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: ;
      endcase
    end
  end

  // Control registers and debug counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl            <= '0;
      cpb             <= CPB_RST;
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
      char_count      <= '0;
      fifo_wr_count   <= '0;
      fifo_full_count <= '0;
    end else begin
      if (wr_acc) begin
        if (addr == 4'd1) ctrl <= din[1:0];
        if (addr == 4'd4) cpb  <= din[31:0];
        if (addr[3:2] == 2'b11) scratch[addr[1:0]] <= din[31:0];
      end
      if (rx_valid) begin
        char_count    <= char_count + 32'd1;
        fifo_wr_count <= fifo_wr_count + 32'd1;
      end
      if (drop) fifo_full_count <= fifo_full_count + 32'd1;
    end
  end

  logic [31:0] rstat;
  assign rstat = {4'b0, rd_ptr, 4'b0, wr_ptr, head, 2'b0, full, empty,
                  1'b0, rx_valid, brk, ~empty};

  always_comb begin
    dout = '0;
    case (addr)
      4'd0, 4'd5:                dout = {24'b0, rx_buf};
      4'd1:                      dout = {30'b0, ctrl};
      4'd2:                      dout = rstat;
      4'd3:                      dout = {31'b0, tx_idle};
      4'd4:                      dout = cpb;
      4'd7:                      dout = char_count;
      4'd8:                      dout = fifo_wr_count;
      4'd9:                      dout = fifo_full_count;
      4'd12, 4'd13, 4'd14, 4'd15: dout = scratch[addr[1:0]];
      default:                   dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_periph.sv
// Testbench for uart_periph: directed and randomized serial traffic against a queue-based reference model.
module tb_uart_periph;

`ifdef UART_SIM_BAUD_EN
  localparam logic [31:0] CPB_RST = 32'd40;
`else
  localparam logic [31:0] CPB_RST = 32'd217;
`endif

  logic        clk = 1'b0, reset = 1'b1, cs = 1'b0, wen = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] din = 32'd0, dout;
  logic        rxd_drv = 1'b1, loopback = 1'b0, txd, rxd;
  int          vectors = 0, errors = 0, cyc = 0, cpb = 40;

  logic [7:0]  q[$];
  logic [3:0]  m_wrp = 4'd0, m_rdp = 4'd0;
  logic        m_brk = 1'b0;
  logic [31:0] m_char = 0, m_wr = 0, m_full = 0;

  assign rxd = loopback ? txd : rxd_drv;

  uart_periph #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr),
    .din(din), .dout(dout), .RxD(rxd), .TxD(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; wen = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; addr = a;
    #1 d = dout;
    cs = 1'b0;
  endtask

  task automatic pop_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; addr = a;
    #1 d = dout;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (cpb) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (cpb) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (cpb) @(negedge clk);
  endtask

  // Reference behaviour of one received frame
  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      m_char++;
      m_wr++;
      m_brk = 1'b0;
      if (q.size() < 16) begin
        q.push_back(b);
        m_wrp++;
      end else begin
        m_full++;
      end
    end else if (b == 8'h00) begin
      m_brk = 1'b1;
    end
  endtask

  task automatic model_pop(output logic [7:0] b);
    b = q.pop_front();
    m_rdp++;
  endtask

  task automatic check_rstat(input string tag);
    logic [31:0] d, exp, mask;
    logic        emp;
    emp  = (q.size() == 0);
    exp  = {4'b0, m_rdp, 4'b0, m_wrp, (emp ? 8'h00 : q[0]), 2'b0,
            (q.size() == 16), emp, 1'b0, 1'b0, m_brk, ~emp};
    mask = emp ? 32'hFFFF_00FF : 32'hFFFF_FFFF;
    peek(4'd2, d);
    check(tag, d & mask, exp);
  endtask

  task automatic check_counters(input string tag);
    logic [31:0] d;
    peek(4'd7, d); check({tag, " CHAR_COUNT"}, d, m_char);
    peek(4'd8, d); check({tag, " FIFO_WR_COUNT"}, d, m_wr);
    peek(4'd9, d); check({tag, " FIFO_FULL_COUNT"}, d, m_full);
  endtask

  initial begin
    logic [31:0] d, sv;
    logic [7:0]  b, eb;
    logic        st;
    int          t0, r;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset TxD", {31'b0, txd}, 32'd1);
    peek(4'd1, d); check("reset CTRL", d, 32'd0);
    peek(4'd4, d); check("reset CPB", d, CPB_RST);
    peek(4'd2, d); check("reset RSTAT", d, 32'h0000_0010);
    peek(4'd3, d); check("reset TSTAT", d, 32'd1);
    check_counters("reset");
    for (int a = 12; a < 16; a++) begin
      peek(a[3:0], d); check($sformatf("reset scratch%0d", a), d, 32'd0);
    end

    // Scratch and unmapped registers
    for (int a = 12; a < 16; a++) begin
      sv = $urandom;
      wr(a[3:0], sv);
      peek(a[3:0], d); check($sformatf("scratch%0d readback", a), d, sv);
    end
    wr(4'd6, $urandom);
    peek(4'd6, d); check("addr6 reads zero", d, 32'd0);
    wr(4'd10, $urandom);
    peek(4'd10, d); check("addr10 reads zero", d, 32'd0);

    // Transmit 0xA5 with a rejected second write mid-frame
    cpb = 40;
    wr(4'd4, 32'd40);
    wr(4'd1, 32'd2);
    peek(4'd1, d); check("CTRL readback", d, 32'd2);
    wr(4'd0, 32'h0000_00A5);
    t0 = cyc;
    b  = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) wr(4'd0, 32'h0000_000F);
      wait_until(t0 + k * cpb + cpb / 2);
      st = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      check($sformatf("tx bit%0d", k), {31'b0, txd}, {31'b0, st});
      if (k == 5) begin
        cs = 1'b1; wen = 1'b0; addr = 4'd3;
        #1 check("TC busy", dout, 32'd0);
        cs = 1'b0;
      end
    end
    wait_until(t0 + 10 * cpb + 2);
    peek(4'd3, d); check("TC after frame", d, 32'd1);
    wait_until(t0 + 11 * cpb);
    check("TxD idle after frame", {31'b0, txd}, 32'd1);
    wait_until(t0 + 12 * cpb + cpb / 2);
    check("no second frame", {31'b0, txd}, 32'd1);

    // Loopback receive
    loopback = 1'b1;
    wr(4'd1, 32'd3);
    wr(4'd0, 32'h0000_003C);
    t0 = cyc;
    wait_until(t0 + 10 * cpb + 40);
    model_frame(8'h3C, 1'b1);
    check_rstat("loopback RSTAT");
    pop_read(4'd0, d);
    model_pop(eb);
    check("loopback DR", d, {24'b0, eb});
    check_counters("loopback");
    check_rstat("loopback RSTAT after pop");
    loopback = 1'b0;

    // Fill past capacity
    wr(4'd1, 32'd1);
    for (int i = 0; i < 17; i++) begin
      send_frame(i[7:0], 1'b1);
      model_frame(i[7:0], 1'b1);
    end
    check_rstat("full RSTAT");
    check_counters("full");
    for (int i = 0; i < 16; i++) begin
      pop_read(4'd0, d);
      model_pop(eb);
      check($sformatf("drain%0d", i), d, {24'b0, eb});
    end
    check_rstat("drained RSTAT");

    // Long QUEUE strobe pops once; read while empty changes nothing
    for (int i = 0; i < 2; i++) begin
      b = $urandom;
      send_frame(b, 1'b1);
      model_frame(b, 1'b1);
    end
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; addr = 4'd5;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("held QUEUE cycle%0d", i), dout, {24'b0, q[0]});
      @(negedge clk);
    end
    cs = 1'b0;
    model_pop(eb);
    check_rstat("after held QUEUE");
    pop_read(4'd0, d);
    model_pop(eb);
    check("second byte", d, {24'b0, eb});
    pop_read(4'd0, d);
    check_rstat("pop while empty");

    // Break, then a valid byte clears it
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (12 * cpb) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * cpb) @(negedge clk);
    model_frame(8'h00, 1'b0);
    check_rstat("break RSTAT");
    check_counters("break");
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    check_rstat("break cleared RSTAT");
    pop_read(4'd0, d);
    model_pop(eb);
    check("byte after break", d, {24'b0, eb});

    // Disabling the receiver mid-frame aborts it
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (cpb + cpb / 2) @(negedge clk);
    wr(4'd1, 32'd0);
    rxd_drv = 1'b1;
    repeat (11 * cpb) @(negedge clk);
    wr(4'd1, 32'd1);
    check_rstat("abort RSTAT");
    check_counters("abort");

    // Randomized traffic with varying bit period and stop errors
    for (int n = 0; n < 20; n++) begin
      cpb = $urandom_range(16, 48);
      wr(4'd4, cpb);
      b  = $urandom;
      st = 1'b1;
      r  = $urandom_range(0, 9);
      if (r == 0) begin
        b  = 8'h00;
        st = 1'b0;
      end else if (r == 1) begin
        st = 1'b0;
      end
      send_frame(b, st);
      model_frame(b, st);
      check_rstat($sformatf("random%0d RSTAT", n));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        pop_read(($urandom_range(0, 1) == 1) ? 4'd5 : 4'd0, d);
        model_pop(eb);
        check($sformatf("random%0d read", n), d, {24'b0, eb});
      end
    end
    peek(4'd4, d); check("CPB readback", d, cpb);
    check_counters("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped 8N1 UART peripheral for the CPU system bus. Combines a transmitter, a receiver and a 16-entry receive FIFO behind a 16-word register window. Includes status, baud-divisor and debug-counter registers. Sits on the peripheral bus as one chip-selected slave with an asynchronous (combinational) read path.

## Interface
- WIDTH, 32, bus data width; only 32 is supported.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset. It clears all state immediately and is released synchronously.
- cs  in  1  chip select.
- wen  in  1  1 = write access, 0 = read access (qualified by cs).
- addr  in  4  word register index.
- din  in  WIDTH  write data.
- dout  out  WIDTH  read data; combinational from addr and state.
- RxD  in  1  serial input; idle high.
- TxD  out  1  serial output; idle high; reset value 1.

## Operation
Register map (R = read, W = write):
- 0 DR. W: transmit din[7:0] when CTRL.TX_EN=1 and the transmitter is idle; otherwise the write is ignored. R: {24'b0, rx_buf}; the read pops the FIFO.
- 1 CTRL. R/W; bit0 RX_EN, bit1 TX_EN; reset 0.
- 2 RSTAT. R:
  - bit0 RXNE = ~empty; bit1 BREAK; bit2 rx_valid.
  - bit4 empty; bit5 full.
  - [15:8] FIFO head byte; [19:16] write pointer; [27:24] read pointer; all other bits 0.
- 3 TSTAT. R: bit0 TC = transmitter idle.
- 4 CPB. R/W; clock cycles per bit; reset 217, or 40 (see Configuration).
- 5 QUEUE. R: alias of a DR read, including the pop.
- 7 CHAR_COUNT. R: frames received with a valid stop bit.
- 8 FIFO_WR_COUNT. R: FIFO write attempts.
- 9 FIFO_FULL_COUNT. R: write attempts made while the FIFO was full (those bytes are dropped).
- 12–15. R/W scratch registers; reset 0.
- Addresses 6, 10 and 11 read 0; writes to them are ignored. All counters are 32 bits, wrap at 2^32 and reset to 0.

Transmitter:
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts CPB cycles.
- Busy from the accept cycle until the stop bit completes.

Receiver (active only while RX_EN=1):
- RxD passes through a 2-flop synchronizer.
- A falling edge starts a frame. The start bit is sampled CPB/2 cycles later; if it reads high, return to idle.
- Data bits and the stop bit are sampled at CPB intervals from that point.
- Stop bit = 1: rx_valid pulses for 1 cycle with the byte, CHAR_COUNT increments, and BREAK clears.
- Stop bit = 0 with data = 0x00: set BREAK and discard the byte. Any other stop-bit error: discard the byte.
- Clearing RX_EN mid-frame aborts the frame and returns to idle.

Receive FIFO:
- 16 × 8 bits; 4-bit read/write pointers that wrap modulo 16.
- Head byte is visible combinationally.
- Each rx_valid produces one write attempt. A write while full is dropped and the pointers are unchanged.

Read/pop protocol:
- rx_buf loads the FIFO head every cycle in which no DR/QUEUE read is in progress.
- A contiguous DR/QUEUE read strobe (cs=1, wen=0, addr 0 or 5), of any length, pops exactly one entry, on its first cycle. The strobe returns the byte captured in rx_buf before the pop.
- A pop while empty is ignored; rx_buf then holds its stale value.
- Simultaneous push and pop in the same cycle: both take effect.
- The count is unchanged when the FIFO was full, and the push succeeds.

## Timing
- Register writes take effect on the clk edge of the access. Reads are combinational in the same cycle.
- TxD falls on the clock edge after the accepting DR write. TC reads 0 from the next cycle until 10×CPB cycles later.
- rx_valid fires at the mid-point of the stop bit, i.e. ≈9.5×CPB + 3 cycles after the RxD falling edge. The FIFO write and the counter updates occur on the following edge.
- CPB changes take effect at the next frame start.

## Configuration
- UART_SIM_BAUD_EN defined: CPB resets to 40, giving short simulation frames.
- UART_SIM_BAUD_EN undefined: CPB resets to 217 (25 MHz clock → 115200 baud).
- No other behaviour differs.

## Test plan
- Reset: CTRL=0, CPB=40 (macro defined), TxD=1, RSTAT bit4=1 and bit0=0, all counters and scratch registers 0.
- TX: CTRL=2, write DR=0xA5 → TxD shows 0,1,0,1,0,0,1,0,1,1, each bit 40 cycles; TC=0 during the frame, then 1. A second DR write while busy produces no extra frame.
- RX loopback: CTRL=3, TxD tied to RxD, send 0x3C → RSTAT bit0=1, DR read returns 0x3C, CHAR_COUNT=1, RXNE=0 afterwards.
- FIFO full: receive 17 bytes (0x00..0x10) → full=1, FIFO_WR_COUNT=17, FIFO_FULL_COUNT=1. Sixteen reads return 0x00..0x0F and 0x10 is lost.
- Pop semantics: a QUEUE read strobe held 5 cycles pops one entry; a read while empty leaves the pointers unchanged.
- Break: RxD held low for 12×CPB → BREAK=1, no FIFO write. A following valid byte 0x55 clears BREAK.
